// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the restoring divider.
// Optional divide-by-zero detection is enabled by defining DIV_BY_ZERO_CHECK_EN.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int DEFAULT_WIDTH = 4;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    // The step counter must count down from width-1, and it needs at least one bit.
    function automatic int counterWidth(input int width);
        return ($clog2(width) < 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/partial_subtractor.sv
// One restoring-division step: trial subtract of the divisor from the shifted remainder.
// This is the divide-side counterpart of the multiplier's partial-product block.
module partial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   shiftedRem_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] nextRem_o,
    output logic             qBit_o
);

    logic [WIDTH:0] trial;

    assign trial  = shiftedRem_i - {1'b0, divisor_i};
    assign qBit_o = ~trial[WIDTH];

    // The kept remainder is always below the divisor, so its top bit is provably zero.
    assign nextRem_o = trial[WIDTH] ? shiftedRem_i[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/sequential_divider.sv
// Unsigned restoring divider producing one quotient bit per clock behind a start/done handshake.
// Define DIV_BY_ZERO_CHECK_EN to short-circuit a zero divisor straight to DONE with div_by_zero set.
module sequential_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = counterWidth(WIDTH);

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] divisor_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH:0]   shiftedRem_d;
    logic [WIDTH-1:0] rem_d;
    logic             qBit_d;

`ifdef DIV_BY_ZERO_CHECK_EN
    logic             dbz_q;
`endif

    // The quotient register doubles as the dividend shift register; its MSB feeds the remainder.
    assign shiftedRem_d = {rem_q, quot_q[WIDTH-1]};

    partial_subtractor #(
        .WIDTH(WIDTH)
    ) u_step (
        .shiftedRem_i(shiftedRem_d),
        .divisor_i   (divisor_q),
        .nextRem_o   (rem_d),
        .qBit_o      (qBit_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef DIV_BY_ZERO_CHECK_EN
            dbz_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        divisor_q <= divisor;
`ifdef DIV_BY_ZERO_CHECK_EN
                        if (divisor == '0) begin
                            quot_q  <= '1;
                            rem_q   <= dividend;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else
`endif
                        begin
                            rem_q   <= '0;
                            quot_q  <= dividend;
                            count_q <= CW'(WIDTH - 1);
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q  <= rem_d;
                    quot_q <= {quot_q[WIDTH-2:0], qBit_d};
                    if (count_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        count_q <= count_q - CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
`ifdef DIV_BY_ZERO_CHECK_EN
                    dbz_q   <= 1'b0;
`endif
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

`ifdef DIV_BY_ZERO_CHECK_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: directed cases, full operand sweep and random traffic.
// Expected behaviour for a zero divisor follows DIV_BY_ZERO_CHECK_EN when it is defined.
module tb_sequential_divider;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int checksTotal  = 0;
    int checksPassed = 0;
    int prevQ        = 0;
    int prevR        = 0;
    bit hasPrev      = 1'b0;

    sequential_divider #(
        .WIDTH(WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checksTotal++;
        if (actual == expected) checksPassed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    // Reference model: plain integer division, with the defined zero-divisor results.
    task automatic refDivide(input int a, input int b,
                             output int q, output int r, output int dz,
                             output int latency, output int busyCycles);
        q          = (b == 0) ? MAXV : a / b;
        r          = (b == 0) ? a : a % b;
        dz         = 0;
        latency    = WIDTH + 1;
        busyCycles = WIDTH;
`ifdef DIV_BY_ZERO_CHECK_EN
        if (b == 0) begin
            dz         = 1;
            latency    = 1;
            busyCycles = 0;
        end
`endif
    endtask

    // Issues one division and checks handshake timing and results.
    // noiseMode 0: quiet inputs; 1: random start/operands while in flight; 2: start held with 7/7.
    task automatic applyStimulus(input int a, input int b, input int noiseMode);
        int eq, er, edz, elat, ebusy;
        int cycles    = 0;
        int busyCount = 0;
        int gotQ      = 0;
        int gotR      = 0;
        int gotDz     = 0;
        int gotBusy   = 0;
        bit gotDone   = 1'b0;
        refDivide(a, b, eq, er, edz, elat, ebusy);
        @(negedge clk);
        if (hasPrev) begin
            checkOutput("holdQ", int'(quotient), prevQ);
            checkOutput("holdR", int'(remainder), prevR);
            checkOutput("idleDone", int'(done), 0);
            checkOutput("idleDbz", int'(div_by_zero), 0);
        end
        start    = 1'b1;
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        @(posedge clk);
        while (!gotDone && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (busy) busyCount++;
            if (done) begin
                gotDone = 1'b1;
                gotQ    = int'(quotient);
                gotR    = int'(remainder);
                gotDz   = int'(div_by_zero);
                gotBusy = int'(busy);
            end
            case (noiseMode)
                1: begin
                    start    = 1'($urandom_range(0, 1));
                    dividend = WIDTH'($urandom);
                    divisor  = WIDTH'($urandom);
                end
                2: begin
                    start    = 1'b1;
                    dividend = WIDTH'(7);
                    divisor  = WIDTH'(7);
                end
                default: begin
                    start    = 1'b0;
                    dividend = WIDTH'($urandom);
                    divisor  = WIDTH'($urandom);
                end
            endcase
        end
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput($sformatf("doneSeen %0d/%0d", a, b), int'(gotDone), 1);
        if (gotDone) begin
            checkOutput($sformatf("latency %0d/%0d", a, b), cycles, elat);
            checkOutput($sformatf("busyCycles %0d/%0d", a, b), busyCount, ebusy);
            checkOutput($sformatf("quotient %0d/%0d", a, b), gotQ, eq);
            checkOutput($sformatf("remainder %0d/%0d", a, b), gotR, er);
            checkOutput($sformatf("divByZero %0d/%0d", a, b), gotDz, edz);
            checkOutput($sformatf("busyAtDone %0d/%0d", a, b), gotBusy, 0);
        end
        prevQ   = eq;
        prevR   = er;
        hasPrev = 1'b1;
    endtask

    // Watches for spurious done pulses while the divider should stay idle.
    task automatic idleWatch(input int n);
        int extraDone = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) extraDone++;
        end
        checkOutput("noSecondDone", extraDone, 0);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1 rst = 1'b1;
        #2;
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetDone", int'(done), 0);
        checkOutput("resetQ", int'(quotient), 0);
        checkOutput("resetR", int'(remainder), 0);
        checkOutput("resetDbz", int'(div_by_zero), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed cases");
        applyStimulus(13, 3, 0);
        applyStimulus(15, 1, 0);
        applyStimulus(5, 7, 0);
        applyStimulus(0, 9, 0);
        applyStimulus(9, 0, 0);

        $display("[TB] start ignored while busy");
        applyStimulus(14, 4, 2);
        idleWatch(8);

        $display("[TB] reset in the middle of an operation");
        @(negedge clk);
        start    = 1'b1;
        dividend = WIDTH'(11);
        divisor  = WIDTH'(2);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("midResetBusy", int'(busy), 0);
        checkOutput("midResetDone", int'(done), 0);
        checkOutput("midResetQ", int'(quotient), 0);
        checkOutput("midResetR", int'(remainder), 0);
        checkOutput("midResetDbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst   = 1'b0;
        prevQ = 0;
        prevR = 0;
        applyStimulus(11, 2, 0);

        $display("[TB] exhaustive sweep at full throughput");
        for (int a = 0; a <= MAXV; a++) begin
            for (int b = 0; b <= MAXV; b++) begin
                applyStimulus(a, b, 0);
            end
        end

        $display("[TB] random traffic with start noise");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)), 1);
        end
        idleWatch(4);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/sequential_divider.md
# sequential_divider

Unsigned restoring divider for the Laboratorio 2 arithmetic unit. It computes `quotient = dividend / divisor` and `remainder = dividend % divisor` by iterated shift-and-subtract, one quotient bit per clock. It is the inverse datapath of the shift-and-add multiplier built from `partial_multiplier`, and it sits beside that multiplier in the ALU, behind the same start/done handshake.

## Interface

Parameters:
- `WIDTH`, default 4: operand and result width in bits. Must be ≥ 2.

Ports:
- `clk`, input, 1 bit: single clock. All state changes on the rising edge.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `start`, input, 1 bit: request a division. Sampled only in IDLE.
- `dividend`, input, WIDTH bits: unsigned dividend. Captured when `start` is accepted.
- `divisor`, input, WIDTH bits: unsigned divisor. Captured when `start` is accepted.
- `busy`, output, 1 bit: high while in RUN.
- `done`, output, 1 bit: one-cycle pulse in the DONE state.
- `quotient`, output, WIDTH bits: result. Valid from `done` until the next accepted `start`.
- `remainder`, output, WIDTH bits: result. Valid from `done` until the next accepted `start`.
- `div_by_zero`, output, 1 bit: flag, valid alongside `done`.

## Operation

- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `start=1` at an edge: capture the operands. Clear the partial remainder (WIDTH+1 bits). Load the quotient/shift register with `dividend`. Set the step counter to WIDTH-1. Go to RUN.
  - `start=0`: remain in IDLE.
- **RUN step** (every edge):
  - Form `trial = {rem[WIDTH-1:0], q_msb} - {1'b0, divisor}`.
  - If `trial` is non-negative (bit WIDTH = 0): rem ← trial and shift 1 into the quotient LSB.
  - Otherwise: rem unchanged except for the shift, and shift 0 into the quotient LSB.
  - Decrement the counter. After the step with counter = 0, go to DONE.
- **DONE:**
  - Assert `done` for one cycle.
  - `quotient` and `remainder` hold the results.
  - Return to IDLE on the next edge.
- **start handling:** `start` asserted in RUN or DONE is ignored. It is not queued.
- **Input stability:** operands may change after acceptance without affecting the operation in flight.
- **Outputs:** `quotient`/`remainder` are held in IDLE. They change only during RUN of a new operation.
- **Reset** (asynchronous, at any time, including mid-RUN):
  - State goes to IDLE.
  - `busy=0`, `done=0`, `div_by_zero=0`, `quotient=0`, `remainder=0`, counter = 0.
  - The operation in flight is abandoned.
- **Arithmetic:** all operands unsigned. The remainder is always strictly less than the divisor when the divisor is nonzero.

## Timing

- Let E0 be the accepting edge.
- `busy` is high in the cycles after E0 through E_WIDTH.
- The result is registered at E_WIDTH. `done` is high in the cycle after E_WIDTH (latency WIDTH+1 cycles from E0 to `done`).
- Throughput: one division per WIDTH+2 cycles. The earliest next acceptance is at edge E_WIDTH+2.
- No combinational path from inputs to outputs.

## Configuration

Macro `DIV_BY_ZERO_CHECK_EN`:
- **Defined:** if `divisor == 0` at acceptance, go directly IDLE→DONE at E0.
  - Outputs: `quotient` = all ones, `remainder = dividend`, `div_by_zero=1` during `done`.
  - `done` appears in the cycle after E0. `busy` never rises.
  - `div_by_zero` returns to 0 with `done`.
- **Undefined:** no detection. Divisor 0 runs the normal WIDTH steps. The algorithm naturally yields `quotient` = all ones and `remainder = dividend`. `div_by_zero` is tied to 0.

## Structure

- **Package `divider_pkg`:** state enum typedef (IDLE, RUN, DONE), plus the localparam for counter width, `$clog2(WIDTH)`.
- **Sub-module `partial_subtractor`:** combinational, one restoring step. Inputs: shifted remainder, divisor. Outputs: next remainder, quotient bit. This mirrors the multiplier's one-bit partial-product block.
- The top level holds the FSM, counter and registers.

## Test plan

All with WIDTH=4:
- **Basic:** 13/3, `start` pulsed one cycle → `done` 5 cycles later with `quotient=4`, `remainder=1`, `div_by_zero=0`. `busy` high for exactly 4 cycles.
- **Extremes:**
  - 15/1 → `quotient=15`, `remainder=0`.
  - 5/7 → `quotient=0`, `remainder=5`.
  - 0/9 → 0, 0.
- **Divide by zero:** 9/0.
  - Macro defined: `done` 1 cycle after acceptance, `quotient=15`, `remainder=9`, `div_by_zero=1`.
  - Macro undefined: `done` after 5 cycles, same `quotient`/`remainder`, `div_by_zero=0`.
- **Busy protection:** 14/4 accepted, then `start` with 7/7 pulsed during RUN and during DONE → single result, `quotient=3`, `remainder=2`. No second `done`.
- **Reset mid-op:** assert `rst` 2 cycles into 11/2 → all outputs 0 immediately (asynchronous). A new 11/2 then completes with `quotient=5`, `remainder=1`.
- **Exhaustive sweep:** all 256 operand pairs back to back at maximum throughput → every result matches the reference model. Results hold stable between `done` and the next acceptance.
